// File: rtl/epwm_pkg.sv
// rtl/epwm_pkg.sv - shared constants, state encoding and helpers for the ePWM dead-band stage
// Contents: register byte offsets, CTRL/TZSTAT bit indices, dead-band FSM states,
//           delay counter width, AHB byte-lane decode helper.
package epwm_pkg;

    localparam int DLY_W = 16;

    localparam logic [15:0] OFS_CTRL   = 16'h0000;
    localparam logic [15:0] OFS_DB     = 16'h0004;
    localparam logic [15:0] OFS_TZSTAT = 16'h0008;

    localparam int CTRL_DBEN = 0;
    localparam int CTRL_TZEN = 1;
    localparam int CTRL_TZIE = 2;

    localparam int TZ_FLG = 0;
    localparam int TZ_RAW = 1;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DLY_H = 3'd1,
        ST_H_ON  = 3'd2,
        ST_DLY_L = 3'd3,
        ST_L_ON  = 3'd4
    } db_state_e;

    // Byte lanes touched by an AHB transfer of the given size at the given address.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] lanes;
        case (size)
            3'd0:    lanes = 4'b0001 << addr;
            3'd1:    lanes = addr[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/epwm_db_chan.sv
// rtl/epwm_db_chan.sv - one dead-band channel: FSM, delay counter, registered gate pair
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   dben           dead-band enable (0 = registered bypass)
//   force_off      trip force: gates 0, FSM to OFF
//   red, fed       rising/falling-edge delays, sampled at counter load
//   pwm_in         raw PWM from the ePWM core
//   pwm_h, pwm_l   high-side / low-side gates
module epwm_db_chan
    import epwm_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             dben,
    input  logic             force_off,
    input  logic [DLY_W-1:0] red,
    input  logic [DLY_W-1:0] fed,
    input  logic             pwm_in,
    output logic             pwm_h,
    output logic             pwm_l
);

    db_state_e        state;
    logic [DLY_W-1:0] cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_OFF;
            cnt   <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else if (force_off) begin
            state <= ST_OFF;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else if (!dben) begin
            state <= ST_OFF;
            pwm_h <= pwm_in;
            pwm_l <= ~pwm_in;
        end else begin
            case (state)
                ST_OFF: begin
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                    if (pwm_in) begin
                        state <= ST_DLY_H;
                        cnt   <= red;
                    end else begin
                        state <= ST_DLY_L;
                        cnt   <= fed;
                    end
                end
                // A falling edge during the rising delay wins over expiry, so a
                // pulse shorter than the delay never reaches the high-side gate.
                ST_DLY_H: begin
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                    if (!pwm_in) begin
                        state <= ST_DLY_L;
                        cnt   <= fed;
                    end else if (cnt == '0) begin
                        state <= ST_H_ON;
                        pwm_h <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_H_ON: begin
                    if (!pwm_in) begin
                        state <= ST_DLY_L;
                        cnt   <= fed;
                        pwm_h <= 1'b0;
                    end
                end
                ST_DLY_L: begin
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                    if (pwm_in) begin
                        state <= ST_DLY_H;
                        cnt   <= red;
                    end else if (cnt == '0) begin
                        state <= ST_L_ON;
                        pwm_l <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_L_ON: begin
                    if (pwm_in) begin
                        state <= ST_DLY_H;
                        cnt   <= red;
                        pwm_l <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_epwm_db.sv
// rtl/ahb_epwm_db.sv - three-channel dead-band and trip-zone stage with AHB-Lite registers
// Ports:
//   HCLK, HRESETn       clock, asynchronous active-low reset
//   HSEL..HREADY        AHB-Lite slave inputs
//   HREADYOUT, HRDATA, HRESP  AHB-Lite slave outputs (never stalls, never errors)
//   pwm_in[2:0]         raw PWM from the ePWM core
//   trip_n              asynchronous active-low trip request
//   pwm_h/pwm_l[2:0]    complementary gate outputs
//   irq                 trip interrupt
module ahb_epwm_db
    import epwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [15:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    input  logic [2:0]  pwm_in,
    input  logic        trip_n,
    output logic [2:0]  pwm_h,
    output logic [2:0]  pwm_l,
    output logic        irq
);

    logic [2:0]             ctrl;
    logic [2:0]             ctrl_next;
    logic [31:0]            db;
    logic [31:0]            db_next;
    logic                   tzflg;
    logic                   tz_next;
    logic                   tz_clr;
    logic [SYNC_STAGES-1:0] trip_sync;
    logic                   trip_act;
    logic                   wr_q;
    logic [15:2]            addr_q;
    logic [3:0]             lanes_q;
    logic                   sel_ctrl;
    logic                   sel_db;
    logic                   sel_tz;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Address phase capture; the data phase follows on the next cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            lanes_q <= '0;
        end else if (HREADY) begin
            wr_q <= HSEL & HTRANS[1] & HWRITE;
            if (HSEL & HTRANS[1]) begin
                addr_q  <= HADDR[15:2];
                lanes_q <= byte_lanes(HSIZE, HADDR[1:0]);
            end
        end
    end

    assign sel_ctrl = (addr_q == OFS_CTRL[15:2]);
    assign sel_db   = (addr_q == OFS_DB[15:2]);
    assign sel_tz   = (addr_q == OFS_TZSTAT[15:2]);

    always_comb begin
        ctrl_next = ctrl;
        db_next   = db;
        tz_clr    = 1'b0;
        if (wr_q) begin
            if (sel_ctrl && lanes_q[0]) begin
                ctrl_next = HWDATA[2:0];
            end
            if (sel_db) begin
                for (int b = 0; b < 4; b++) begin
                    if (lanes_q[b]) begin
                        db_next[8*b +: 8] = HWDATA[8*b +: 8];
                    end
                end
            end
            if (sel_tz && lanes_q[0] && HWDATA[TZ_FLG]) begin
                tz_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            trip_sync <= '1;
        end else begin
            trip_sync[0] <= trip_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                trip_sync[i] <= trip_sync[i-1];
            end
        end
    end

    assign trip_act = ~trip_sync[SYNC_STAGES-1];

    // A clear only lands once the synchronised trip has gone away; a new trip
    // always sets. The channels see the next flag value so the gates drop in
    // the same cycle the flag rises.
    assign tz_next = (trip_act & ctrl[CTRL_TZEN]) | (tzflg & ~(tz_clr & ~trip_act));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl  <= '0;
            db    <= '0;
            tzflg <= 1'b0;
            irq   <= 1'b0;
        end else begin
            ctrl  <= ctrl_next;
            db    <= db_next;
            tzflg <= tz_next;
            irq   <= tz_next & ctrl_next[CTRL_TZIE];
        end
    end

    always_comb begin
        HRDATA = '0;
        if (sel_ctrl) begin
            HRDATA[2:0] = ctrl;
        end else if (sel_db) begin
            HRDATA = db;
        end else if (sel_tz) begin
            HRDATA[TZ_FLG] = tzflg;
            HRDATA[TZ_RAW] = trip_act;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_chan
        epwm_db_chan u_chan (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .dben      (ctrl[CTRL_DBEN]),
            .force_off (tz_next),
            .red       (db[15:0]),
            .fed       (db[31:16]),
            .pwm_in    (pwm_in[g]),
            .pwm_h     (pwm_h[g]),
            .pwm_l     (pwm_l[g])
        );
    end

endmodule

// File: tb/tb_ahb_epwm_db.sv
// tb/tb_ahb_epwm_db.sv - directed self-checking bench for ahb_epwm_db
module tb_ahb_epwm_db;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [2:0]  pwm_in;
    logic        trip_n;
    logic [2:0]  pwm_h;
    logic [2:0]  pwm_l;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    ahb_epwm_db #(.SYNC_STAGES(2)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .pwm_in    (pwm_in),
        .trip_n    (trip_n),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l),
        .irq       (irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic ahb_write(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr; HSIZE = size;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        tick();
    endtask

    task automatic ahb_read(input logic [15:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'd2;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        tick(3);
        vectors++;
        if ({pwm_h, pwm_l, irq} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got h=%b l=%b irq=%b want all 0", pwm_h, pwm_l, irq);
        end
        vectors++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bus: got hreadyout=%b hresp=%b want 1/0", HREADYOUT, HRESP);
        end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        logic [2:0] pats [4] = '{3'b101, 3'b010, 3'b111, 3'b000};
        for (int i = 0; i < 4; i++) begin
            pwm_in = pats[i];
            tick();
            vectors++;
            if (pwm_h !== pats[i] || pwm_l !== ~pats[i]) begin
                miscompares++;
                $display("FAIL bypass_%0d: got h=%b l=%b want h=%b l=%b", i, pwm_h, pwm_l, pats[i], ~pats[i]);
            end
        end
    endtask

    task automatic test_db_edges();
        ahb_write(16'h0004, 3'd2, 32'h0003_0005);
        ahb_write(16'h0000, 3'd2, 32'h0000_0001);
        tick(10);
        vectors++;
        if (pwm_l !== 3'b111 || pwm_h !== 3'b000) begin
            miscompares++;
            $display("FAIL db_settle_low: got h=%b l=%b want h=000 l=111", pwm_h, pwm_l);
        end
        pwm_in = 3'b001;
        tick();
        vectors++;
        if (pwm_l[0] !== 1'b0 || pwm_h[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL db_rise_off: got h0=%b l0=%b want 0/0", pwm_h[0], pwm_l[0]);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (pwm_h[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL db_red_gap_%0d: got h0=%b want 0", i, pwm_h[0]);
            end
        end
        tick();
        vectors++;
        if (pwm_h[0] !== 1'b1 || pwm_l[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL db_rise_on: got h0=%b l0=%b want 1/0", pwm_h[0], pwm_l[0]);
        end
        tick(13);
        pwm_in = 3'b000;
        tick();
        vectors++;
        if (pwm_h[0] !== 1'b0 || pwm_l[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL db_fall_off: got h0=%b l0=%b want 0/0", pwm_h[0], pwm_l[0]);
        end
        tick(3);
        vectors++;
        if (pwm_l[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL db_fed_gap: got l0=%b want 0", pwm_l[0]);
        end
        tick();
        vectors++;
        if (pwm_l[0] !== 1'b1 || pwm_h[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL db_fall_on: got h0=%b l0=%b want 0/1", pwm_h[0], pwm_l[0]);
        end
    endtask

    task automatic test_short_pulse();
        ahb_write(16'h0004, 3'd2, 32'h0003_000A);
        tick(2);
        pwm_in = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (pwm_h[1] !== 1'b0 || pwm_l[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL pulse_high_%0d: got h1=%b l1=%b want 0/0", i, pwm_h[1], pwm_l[1]);
            end
        end
        pwm_in = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (pwm_h[1] !== 1'b0 || pwm_l[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL pulse_fed_%0d: got h1=%b l1=%b want 0/0", i, pwm_h[1], pwm_l[1]);
            end
        end
        tick();
        vectors++;
        if (pwm_l[1] !== 1'b1 || pwm_h[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_l_back: got h1=%b l1=%b want 0/1", pwm_h[1], pwm_l[1]);
        end
    endtask

    task automatic test_trip_pulse();
        logic [31:0] rd;
        ahb_write(16'h0004, 3'd2, 32'h0003_0005);
        ahb_write(16'h0000, 3'd2, 32'h0000_0007);
        pwm_in = 3'b001;
        tick(12);
        vectors++;
        if (pwm_h !== 3'b001 || pwm_l !== 3'b110) begin
            miscompares++;
            $display("FAIL trip_pre: got h=%b l=%b want 001/110", pwm_h, pwm_l);
        end
        trip_n = 1'b0;
        tick();
        trip_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (pwm_h[0] !== 1'b1 || irq !== 1'b0) begin
                miscompares++;
                $display("FAIL trip_sync_%0d: got h0=%b irq=%b want 1/0", i, pwm_h[0], irq);
            end
            tick();
        end
        vectors++;
        if (pwm_h !== 3'b000 || pwm_l !== 3'b000 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL trip_force: got h=%b l=%b irq=%b want 000/000/1", pwm_h, pwm_l, irq);
        end
        ahb_read(16'h0008, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL trip_stat: got %h want 00000001", rd);
        end
        ahb_write(16'h0008, 3'd2, 32'h1);
        vectors++;
        if (irq !== 1'b0 || pwm_h !== 3'b000 || pwm_l !== 3'b000) begin
            miscompares++;
            $display("FAIL trip_clear: got h=%b l=%b irq=%b want 000/000/0", pwm_h, pwm_l, irq);
        end
        tick(5);
        vectors++;
        if (pwm_h[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL trip_restart_gap: got h0=%b want 0", pwm_h[0]);
        end
        tick();
        vectors++;
        if (pwm_h !== 3'b001 || pwm_l !== 3'b110) begin
            miscompares++;
            $display("FAIL trip_restart: got h=%b l=%b want 001/110", pwm_h, pwm_l);
        end
    endtask

    task automatic test_trip_held();
        logic [31:0] rd;
        trip_n = 1'b0;
        tick(4);
        vectors++;
        if (pwm_h !== 3'b000 || pwm_l !== 3'b000 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL held_force: got h=%b l=%b irq=%b want 000/000/1", pwm_h, pwm_l, irq);
        end
        ahb_write(16'h0008, 3'd2, 32'h1);
        ahb_read(16'h0008, rd);
        vectors++;
        if (rd !== 32'h3) begin
            miscompares++;
            $display("FAIL held_stat: got %h want 00000003", rd);
        end
        vectors++;
        if (pwm_h !== 3'b000 || pwm_l !== 3'b000 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL held_gates: got h=%b l=%b irq=%b want 000/000/1", pwm_h, pwm_l, irq);
        end
        trip_n = 1'b1;
        tick(3);
        ahb_read(16'h0008, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL held_release_stat: got %h want 00000001", rd);
        end
        ahb_write(16'h0008, 3'd2, 32'h1);
        ahb_read(16'h0008, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL held_cleared: got %h want 00000000", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        ahb_write(16'h0004, 3'd2, 32'h0);
        ahb_write(16'h0006, 3'd0, 32'h005A_0000);
        ahb_read(16'h0004, rd);
        vectors++;
        if (rd !== 32'h005A_0000) begin
            miscompares++;
            $display("FAIL byte_fed: got %h want 005a0000", rd);
        end
        ahb_write(16'h0004, 3'd2, 32'h1122_3344);
        ahb_write(16'h0006, 3'd0, 32'h005A_0000);
        ahb_write(16'h0004, 3'd1, 32'h0000_BEEF);
        ahb_read(16'h0004, rd);
        vectors++;
        if (rd !== 32'h115A_BEEF) begin
            miscompares++;
            $display("FAIL byte_merge: got %h want 115abeef", rd);
        end
        ahb_read(16'h0000, rd);
        vectors++;
        if (rd !== 32'h7) begin
            miscompares++;
            $display("FAIL ctrl_read: got %h want 00000007", rd);
        end
        ahb_read(16'h000C, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h want 00000000", rd);
        end
    endtask

    task automatic test_async_reset();
        ahb_write(16'h0004, 3'd2, 32'h0003_0005);
        pwm_in = 3'b000;
        tick(8);
        vectors++;
        if (pwm_l !== 3'b111) begin
            miscompares++;
            $display("FAIL areset_pre: got l=%b want 111", pwm_l);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        vectors++;
        if (pwm_h !== 3'b000 || pwm_l !== 3'b000 || irq !== 1'b0 || HRDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL areset: got h=%b l=%b irq=%b rdata=%h want all 0", pwm_h, pwm_l, irq, HRDATA);
        end
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    initial begin
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'd2; HWRITE = 1'b0;
        HWDATA = '0; HREADY = 1'b1; pwm_in = 3'b000; trip_n = 1'b1; HRESETn = 1'b0;
        test_reset();
        test_bypass();
        test_db_edges();
        test_short_pulse();
        test_trip_pulse();
        test_trip_held();
        test_byte_lanes();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
